// File: rtl/uart_receiver_if.sv
// Signal bundle between the UART receiver and its user.
// The receiver takes the slave modport; the line driver/consumer takes master.
interface uart_receiver_if;
    logic       rx_serial;
    logic [7:0] received_data;
    logic       data_valid;
    logic       is_receiving;
    logic       framing_error;
    logic       parity_error;

    modport master (
        output rx_serial,
        input  received_data,
        input  data_valid,
        input  is_receiving,
        input  framing_error,
        input  parity_error
    );

    modport slave (
        input  rx_serial,
        output received_data,
        output data_valid,
        output is_receiving,
        output framing_error,
        output parity_error
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 (8E1/8O1 when UART_RX_PARITY_EN is defined), mid-bit sampling.
// Strobes data_valid / framing_error / parity_error are registered one-cycle pulses.
module uart_receiver #(
    parameter int unsigned CLOCKS_PER_BIT = 87,
    parameter bit          PARITY_ODD     = 1'b0
) (
    input logic            clock,
    input logic            reset_n,
    uart_receiver_if.slave bus
);

    localparam int unsigned CntW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLOCKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'((CLOCKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StCleanup
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            armed_q, armed_d;
    logic            rx_meta_q, rx_sync_q;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_mis_q, par_mis_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_mis_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_mis_q <= par_mis_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        busy_d    = busy_q;
        // A break leaves the line low; only a seen-high line re-arms start detection.
        armed_d   = armed_q | rx_sync_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_mis_d = par_mis_q;
`endif

        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                busy_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_mis_d = 1'b0;
`endif
                if (armed_q && !rx_sync_q) begin
                    state_d = StStart;
                    busy_d  = 1'b1;
                end
            end

            StStart: begin
                if (cnt_q == HalfEnd) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_sync_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitEnd) begin
                    cnt_d     = '0;
                    par_mis_d = rx_sync_q ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif

            StStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    state_d = StCleanup;
                    if (!rx_sync_q) begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_mis_q) begin
                        perr_d = 1'b1;
                    end
`endif
                    else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StCleanup: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.received_data = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.is_receiving  = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = perr_q;
`else
    assign bus.parity_error  = 1'b0 & PARITY_ODD;
`endif

endmodule
